// File: rtl/writeback_stage_pkg.sv
// Shared pipeline types for the writeback stage: data/register widths and
// the EX->WB pipeline register layout.
package writeback_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 5;

    typedef logic [DATA_W-1:0] t_data;
    typedef logic [REG_W-1:0]  t_reg;

    typedef struct packed {
        logic  wr_en;
        logic  dataoutv;
        t_reg  dst;
        t_data dataout;
    } t_ex_wb;

endpackage

// File: rtl/writeback_stage_if.sv
// EX->WB pipeline fields plus the data-out valid/ready port of the writeback stage.
// master: upstream/consumer environment; slave: the writeback stage itself.
interface writeback_stage_if;
    import writeback_stage_pkg::*;

    logic  ex_wr_en;
    logic  ex_dataoutv;
    t_reg  ex_dst;
    t_data ex_dataout;
    logic  stall_o;
    t_data dout;
    logic  dout_valid;
    logic  dout_ready;

    modport master (
        output ex_wr_en, ex_dataoutv, ex_dst, ex_dataout, dout_ready,
        input  stall_o, dout, dout_valid
    );

    modport slave (
        input  ex_wr_en, ex_dataoutv, ex_dst, ex_dataout, dout_ready,
        output stall_o, dout, dout_valid
    );

endinterface

// File: rtl/writeback_stage_out_fifo.sv
// First-word-fall-through FIFO for the writeback data-out port.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_out_fifo
    import writeback_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  t_data                    din,
    input  logic                     pop,
    output t_data                    dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    t_data         mem [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; contents are only visible once count says so.
    // A push at full only happens alongside a pop, so overwriting the head is safe.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    a_count_range: assert property (@(posedge clk) disable iff (reset) count_q <= FULL_CNT);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: WB register, GPR write retire and data-out FIFO push with stall.
// Optional WB_BYPASS_EN adds decode-stage forwarding outputs mirroring the GPR write.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int R0_READONLY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    writeback_stage_if.slave              wb_if,
    output logic                          rf_we,
    output t_reg                          rf_waddr,
    output t_data                         rf_wdata,
`ifdef WB_BYPASS_EN
    output logic                          byp_valid,
    output t_reg                          byp_dst,
    output t_data                         byp_data,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    t_ex_wb wb_q, wb_d;
    logic   stall;
    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;
    logic   r0_block;
    t_data  fifo_dout;

    always_comb begin
        wb_d = wb_q;
        if (!stall) begin
            wb_d.wr_en    = wb_if.ex_wr_en;
            wb_d.dataoutv = wb_if.ex_dataoutv;
            wb_d.dst      = wb_if.ex_dst;
            wb_d.dataout  = wb_if.ex_dataout;
        end
    end

    // Clearing the whole entry also gives rf_waddr/rf_wdata a zero reset value.
    always_ff @(posedge clk) begin
        if (reset) wb_q <= '0;
        else       wb_q <= wb_d;
    end

    // A pop in the same cycle frees a slot, so a full FIFO only stalls without one.
    always_comb begin
        fifo_pop  = !fifo_empty && wb_if.dout_ready;
        stall     = wb_q.dataoutv && fifo_full && !fifo_pop;
        fifo_push = wb_q.dataoutv && !stall;
        r0_block  = (R0_READONLY != 0) && (wb_q.dst == '0);
        rf_we     = wb_q.wr_en && !stall && !r0_block;
        rf_waddr  = wb_q.dst;
        rf_wdata  = wb_q.dataout;
    end

    wb_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (wb_q.dataout),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wb_if.stall_o    = stall;
    assign wb_if.dout       = fifo_dout;
    assign wb_if.dout_valid = !fifo_empty;

`ifdef WB_BYPASS_EN
    assign byp_valid = rf_we;
    assign byp_dst   = rf_waddr;
    assign byp_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: GPR writes and data-out pops are checked
// against queues filled when stimulus is driven, plus directed cycle checks.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    writeback_stage_if wb_if0 ();
    writeback_stage_if wb_if1 ();

    logic  rf_we0, rf_we1;
    t_reg  rf_waddr0, rf_waddr1;
    t_data rf_wdata0, rf_wdata1;
    logic [2:0] fifo_count0, fifo_count1;
`ifdef WB_BYPASS_EN
    logic  byp_valid0, byp_valid1;
    t_reg  byp_dst0, byp_dst1;
    t_data byp_data0, byp_data1;
`endif

    // Second instance with a writable R0 shares the same stimulus.
    assign wb_if1.ex_wr_en    = wb_if0.ex_wr_en;
    assign wb_if1.ex_dataoutv = wb_if0.ex_dataoutv;
    assign wb_if1.ex_dst      = wb_if0.ex_dst;
    assign wb_if1.ex_dataout  = wb_if0.ex_dataout;
    assign wb_if1.dout_ready  = wb_if0.dout_ready;

    writeback_stage #(.FIFO_DEPTH(4), .R0_READONLY(1)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .wb_if      (wb_if0.slave),
        .rf_we      (rf_we0),
        .rf_waddr   (rf_waddr0),
        .rf_wdata   (rf_wdata0),
`ifdef WB_BYPASS_EN
        .byp_valid  (byp_valid0),
        .byp_dst    (byp_dst0),
        .byp_data   (byp_data0),
`endif
        .fifo_count (fifo_count0)
    );

    writeback_stage #(.FIFO_DEPTH(4), .R0_READONLY(0)) u_dut_r0 (
        .clk        (clk),
        .reset      (reset),
        .wb_if      (wb_if1.slave),
        .rf_we      (rf_we1),
        .rf_waddr   (rf_waddr1),
        .rf_wdata   (rf_wdata1),
`ifdef WB_BYPASS_EN
        .byp_valid  (byp_valid1),
        .byp_dst    (byp_dst1),
        .byp_data   (byp_data1),
`endif
        .fifo_count (fifo_count1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int rf_pulses = 0;
    logic [31:0] rf_exp[$];
    logic [31:0] dout_exp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic dv, input t_reg dst, input t_data d);
        wb_if0.ex_wr_en    = wr;
        wb_if0.ex_dataoutv = dv;
        wb_if0.ex_dst      = dst;
        wb_if0.ex_dataout  = d;
        if (wr && dst != '0) rf_exp.push_back(32'({dst, d}));
        if (dv) dout_exp.push_back(32'(d));
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, '0, '0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rf_we0) begin
                rf_pulses++;
                if (rf_exp.size() == 0) chk("rf_unexp", 32'(rf_we0), 32'd0);
                else                    chk("rf_sb", 32'({rf_waddr0, rf_wdata0}), rf_exp.pop_front());
            end
            if (wb_if0.dout_valid && wb_if0.dout_ready) begin
                if (dout_exp.size() == 0) chk("dout_unexp", 32'(wb_if0.dout_valid), 32'd0);
                else                      chk("dout_sb", 32'(wb_if0.dout), dout_exp.pop_front());
            end
`ifdef WB_BYPASS_EN
            chk("byp_valid", 32'(byp_valid0), 32'(rf_we0));
            chk("byp_dst", 32'(byp_dst0), 32'(rf_waddr0));
            chk("byp_data", 32'(byp_data0), 32'(rf_wdata0));
`endif
        end
    end

    initial begin
        int base;
        idle();
        wb_if0.dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_stall", 32'(wb_if0.stall_o), 32'd0);
        chk("rst_rf_we", 32'(rf_we0), 32'd0);
        chk("rst_waddr", 32'(rf_waddr0), 32'd0);
        chk("rst_wdata", 32'(rf_wdata0), 32'd0);
        chk("rst_dvalid", 32'(wb_if0.dout_valid), 32'd0);
        chk("rst_count", 32'(fifo_count0), 32'd0);

        // Single GPR write, one-cycle latency, one-cycle pulse.
        tick();
        drive(1'b1, 1'b0, 5'd3, 16'h002A);
        tick();
        idle();
        @(negedge clk);
        chk("wr_we", 32'(rf_we0), 32'd1);
        chk("wr_addr", 32'(rf_waddr0), 32'd3);
        chk("wr_data", 32'(rf_wdata0), 32'h2A);
        tick();
        @(negedge clk);
        chk("wr_we_off", 32'(rf_we0), 32'd0);

        // R0 write: suppressed when read-only, performed otherwise.
        tick();
        drive(1'b1, 1'b0, 5'd0, 16'h0077);
        tick();
        idle();
        @(negedge clk);
        chk("r0_ro_we", 32'(rf_we0), 32'd0);
        chk("r0_rw_we", 32'(rf_we1), 32'd1);
        chk("r0_rw_addr", 32'(rf_waddr1), 32'd0);
        chk("r0_rw_data", 32'(rf_wdata1), 32'h77);

        // Data-out path: valid two cycles after input, popped immediately.
        tick();
        wb_if0.dout_ready = 1'b1;
        drive(1'b0, 1'b1, 5'd0, 16'h0055);
        tick();
        idle();
        @(negedge clk);
        chk("do_valid_c1", 32'(wb_if0.dout_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("do_valid_c2", 32'(wb_if0.dout_valid), 32'd1);
        chk("do_data_c2", 32'(wb_if0.dout), 32'h55);
        chk("do_count_c2", 32'(fifo_count0), 32'd1);
        tick();
        @(negedge clk);
        chk("do_count_c3", 32'(fifo_count0), 32'd0);

        // Fill to full with no consumer; the fifth entry stalls.
        tick();
        wb_if0.dout_ready = 1'b0;
        base = rf_pulses;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1, t_reg'(i), t_data'(i));
            tick();
        end
        idle();
        @(negedge clk);
        chk("full_stall", 32'(wb_if0.stall_o), 32'd1);
        chk("full_count", 32'(fifo_count0), 32'd4);
        chk("full_rf_we", 32'(rf_we0), 32'd0);
        chk("full_pulses", 32'(rf_pulses - base), 32'd4);
        tick();
        @(negedge clk);
        chk("hold_stall", 32'(wb_if0.stall_o), 32'd1);
        chk("hold_rf_we", 32'(rf_we0), 32'd0);
        tick();
        wb_if0.dout_ready = 1'b1;
        #1;
        chk("release_stall", 32'(wb_if0.stall_o), 32'd0);
        @(negedge clk);
        chk("release_we", 32'(rf_we0), 32'd1);
        chk("release_addr", 32'(rf_waddr0), 32'd5);
        tick();
        @(negedge clk);
        chk("release_count", 32'(fifo_count0), 32'd4);
        repeat (8) tick();
        @(negedge clk);
        chk("drain_count", 32'(fifo_count0), 32'd0);
        chk("drain_rf_q", 32'(rf_exp.size()), 32'd0);
        chk("drain_do_q", 32'(dout_exp.size()), 32'd0);

        // Full with consumer ready and a new entry: push and pop together.
        tick();
        wb_if0.dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, '0, t_data'(16'h0010 + i));
            tick();
        end
        idle();
        wb_if0.dout_ready = 1'b1;
        @(negedge clk);
        chk("pp_stall", 32'(wb_if0.stall_o), 32'd0);
        chk("pp_count0", 32'(fifo_count0), 32'd4);
        tick();
        @(negedge clk);
        chk("pp_count1", 32'(fifo_count0), 32'd4);
        repeat (6) tick();
        @(negedge clk);
        chk("pp_drain", 32'(fifo_count0), 32'd0);
        chk("pp_do_q", 32'(dout_exp.size()), 32'd0);

        // Reset while stalled at full discards everything.
        tick();
        wb_if0.dout_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1, t_reg'(i + 8), t_data'(16'h0100 + i));
            tick();
        end
        idle();
        @(negedge clk);
        chk("pre_rst_stall", 32'(wb_if0.stall_o), 32'd1);
        tick();
        reset = 1'b1;
        rf_exp.delete();
        dout_exp.delete();
        tick();
        reset = 1'b0;
        base = rf_pulses;
        @(negedge clk);
        chk("mid_rst_stall", 32'(wb_if0.stall_o), 32'd0);
        chk("mid_rst_dvalid", 32'(wb_if0.dout_valid), 32'd0);
        chk("mid_rst_count", 32'(fifo_count0), 32'd0);
        chk("mid_rst_we", 32'(rf_we0), 32'd0);
        tick();
        wb_if0.dout_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("post_rst_count", 32'(fifo_count0), 32'd0);
        chk("post_rst_pulses", 32'(rf_pulses - base), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
